// File: rtl/mem_wait_ctrl.sv
// Wait-state byte-array memory with request/ready handshake, sub-word
// access, sign/zero extension and access-fault reporting.
module mem_wait_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [1:0]  size,
    input  logic        unsignedLoad,
    output logic [31:0] memData,
    output logic        memReady,
    output logic        busy,
    output logic        accessFault
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [3:0]            r_cnt;
    logic [31:0]           r_addr;
    logic [31:0]           r_wdata;
    logic [1:0]            r_size;
    logic                  r_uns;
    logic                  r_rd;
    logic                  r_wr;
    logic                  r_fault;
    logic [7:0]            r_mem [DEPTH];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_access;
    logic                  w_fault;
    logic [ADDR_WIDTH-1:0] w_a0;
    logic [ADDR_WIDTH-1:0] w_a1;
    logic [ADDR_WIDTH-1:0] w_a2;
    logic [ADDR_WIDTH-1:0] w_a3;
    logic [31:0]           w_load;

    assign w_req    = memRead | memWrite;
    assign w_accept = (r_state == S_IDLE) && w_req;
    assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);

    assign w_a0 = r_addr[ADDR_WIDTH-1:0];
    assign w_a1 = w_a0 + ADDR_WIDTH'(1);
    assign w_a2 = w_a0 + ADDR_WIDTH'(2);
    assign w_a3 = w_a0 + ADDR_WIDTH'(3);

    // Faults are judged on the latched copy so late input changes cannot matter
    assign w_fault = (r_size == 2'b11)
                   | ((r_size == 2'b01) && r_addr[0])
                   | ((r_size == 2'b10) && (r_addr[1:0] != 2'b00))
                   | (|r_addr[31:ADDR_WIDTH])
                   | (r_rd && r_wr);

    always_comb begin
        w_load = '0;
        unique case (r_size)
            2'b00:   w_load = {{24{~r_uns & r_mem[w_a0][7]}}, r_mem[w_a0]};
            2'b01:   w_load = {{16{~r_uns & r_mem[w_a1][7]}},
                               r_mem[w_a1], r_mem[w_a0]};
            default: w_load = {r_mem[w_a3], r_mem[w_a2],
                               r_mem[w_a1], r_mem[w_a0]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_req) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_RESP;
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != S_IDLE);
        memReady    = (r_state == S_RESP);
        accessFault = (r_state == S_RESP) && r_fault;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_size  <= '0;
            r_uns   <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_fault <= 1'b0;
            memData <= '0;
        end else begin
            if (w_accept) begin
                r_cnt   <= 4'(WAIT_CYCLES);
                r_addr  <= address;
                r_wdata <= writeData;
                r_size  <= size;
                r_uns   <= unsignedLoad;
                r_rd    <= memRead;
                r_wr    <= memWrite;
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_access) begin
                r_fault <= w_fault;
                if (w_fault)   memData <= '0;
                else if (r_rd) memData <= w_load;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_access && r_wr && !w_fault) begin
            r_mem[w_a0] <= r_wdata[7:0];
            if (r_size != 2'b00) r_mem[w_a1] <= r_wdata[15:8];
            if (r_size == 2'b10) begin
                r_mem[w_a2] <= r_wdata[23:16];
                r_mem[w_a3] <= r_wdata[31:24];
            end
        end
    end

endmodule

// File: tb/tb_mem_wait_ctrl.sv
// Directed bench for mem_wait_ctrl: a 2-wait-state instance and a
// zero-wait instance share one request bus.
module tb_mem_wait_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  size;
    logic        unsignedLoad;
    logic [31:0] a_data, b_data;
    logic        a_rdy, b_rdy, a_busy, b_busy, a_flt, b_flt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wait_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .address(address),
        .writeData(writeData), .memRead(memRead), .memWrite(memWrite),
        .size(size), .unsignedLoad(unsignedLoad), .memData(a_data),
        .memReady(a_rdy), .busy(a_busy), .accessFault(a_flt)
    );

    mem_wait_ctrl #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .address(address),
        .writeData(writeData), .memRead(memRead), .memWrite(memWrite),
        .size(size), .unsignedLoad(unsignedLoad), .memData(b_data),
        .memReady(b_rdy), .busy(b_busy), .accessFault(b_flt)
    );

    // Issue one access, wait for the selected instance's memReady.
    // lat = edges after the accepting edge (0 on timeout).
    task automatic run(input bit sel, input bit rd, input bit wr,
                       input logic [1:0] sz, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] data, output logic flt,
                       output int lat, output int bcnt);
        @(negedge clk);
        memRead = rd; memWrite = wr; size = sz;
        unsignedLoad = uns; address = addr; writeData = wd;
        @(posedge clk);
        #1;
        memRead = 1'b0; memWrite = 1'b0;
        lat = 0; bcnt = 0; data = 'x; flt = 1'bx;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (sel ? b_busy : a_busy) bcnt++;
            if (sel ? b_rdy : a_rdy) begin
                lat  = i;
                data = sel ? b_data : a_data;
                flt  = sel ? b_flt : a_flt;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; memRead = 0; memWrite = 0;
        address = 0; writeData = 0; size = 0; unsignedLoad = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({a_data, a_rdy, a_busy, a_flt} !== 35'd0 ||
            {b_data, b_rdy, b_busy, b_flt} !== 35'd0) begin
            failures++;
            $display("FAIL reset_outputs a=%h/%b%b%b b=%h/%b%b%b want 0",
                     a_data, a_rdy, a_busy, a_flt,
                     b_data, b_rdy, b_busy, b_flt);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_store_word();
        logic [31:0] d; logic f; int lat, bc;
        run(0, 0, 1, 2'b10, 0, 32'h40, 32'h8BADF00D, d, f, lat, bc);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL sw_latency got %0d want 3", lat);
        end
        checks++;
        if (bc !== 3) begin
            failures++;
            $display("FAIL sw_busy_cycles got %0d want 3", bc);
        end
        checks++;
        if (f !== 1'b0) begin
            failures++;
            $display("FAIL sw_fault got %b want 0", f);
        end
        checks++;
        if (a_busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_resp got %b want 0", a_busy);
        end
        run(0, 1, 0, 2'b10, 0, 32'h40, 0, d, f, lat, bc);
        checks++;
        if (d !== 32'h8BADF00D || f !== 1'b0) begin
            failures++;
            $display("FAIL lw_40 got %h/%b want 8badf00d/0", d, f);
        end
    endtask

    task automatic test_subword_load();
        logic [31:0] d; logic f; int lat, bc;
        logic [1:0]  sz [5] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
        bit          un [5] = '{0, 1, 0, 1, 0};
        logic [31:0] ad [5] = '{32'h43, 32'h43, 32'h42, 32'h42, 32'h40};
        logic [31:0] ex [5] = '{32'hFFFFFF8B, 32'h0000008B, 32'hFFFF8BAD,
                                32'h00008BAD, 32'h0000000D};
        for (int i = 0; i < 5; i++) begin
            run(0, 1, 0, sz[i], un[i], ad[i], 0, d, f, lat, bc);
            checks++;
            if (d !== ex[i] || f !== 1'b0) begin
                failures++;
                $display("FAIL subload_%0d got %h/%b want %h/0",
                         i, d, f, ex[i]);
            end
        end
    endtask

    task automatic test_subword_store();
        logic [31:0] d; logic f; int lat, bc;
        run(0, 0, 1, 2'b00, 0, 32'h41, 32'h000000AA, d, f, lat, bc);
        checks++;
        if (a_data !== 32'h0000000D) begin
            failures++;
            $display("FAIL memdata_hold_on_write got %h want 0000000d",
                     a_data);
        end
        run(0, 1, 0, 2'b10, 0, 32'h40, 0, d, f, lat, bc);
        checks++;
        if (d !== 32'h8BADAA0D) begin
            failures++;
            $display("FAIL sb_readback got %h want 8badaa0d", d);
        end
        run(0, 0, 1, 2'b01, 0, 32'h42, 32'hCAFE1234, d, f, lat, bc);
        run(0, 1, 0, 2'b10, 0, 32'h40, 0, d, f, lat, bc);
        checks++;
        if (d !== 32'h1234AA0D) begin
            failures++;
            $display("FAIL sh_readback got %h want 1234aa0d", d);
        end
    endtask

    task automatic test_faults();
        logic [31:0] d; logic f; int lat, bc;
        bit          rd [5] = '{1, 0, 1, 1, 1};
        bit          wr [5] = '{0, 1, 0, 0, 1};
        logic [1:0]  sz [5] = '{2'b10, 2'b01, 2'b10, 2'b11, 2'b10};
        logic [31:0] ad [5] = '{32'h41, 32'h43, 32'h100, 32'h40, 32'h40};
        for (int i = 0; i < 5; i++) begin
            run(0, rd[i], wr[i], sz[i], 0, ad[i], 32'h5A5A5A5A,
                d, f, lat, bc);
            checks++;
            if (f !== 1'b1 || d !== 32'h0 || lat !== 3) begin
                failures++;
                $display("FAIL fault_%0d got f=%b d=%h lat=%0d want 1/0/3",
                         i, f, d, lat);
            end
        end
        run(0, 1, 0, 2'b10, 0, 32'h40, 0, d, f, lat, bc);
        checks++;
        if (d !== 32'h1234AA0D || f !== 1'b0) begin
            failures++;
            $display("FAIL no_corruption got %h/%b want 1234aa0d/0", d, f);
        end
    endtask

    task automatic test_abort_and_hold();
        logic [31:0] d; logic f; int lat, bc;
        @(negedge clk);
        memWrite = 1; size = 2'b10; address = 32'h50;
        writeData = 32'hFFFFFFFF;
        @(posedge clk);
        #1;
        memWrite = 0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (a_rdy !== 1'b0 || a_busy !== 1'b0 || b_rdy !== 1'b0) begin
            failures++;
            $display("FAIL abort got rdy=%b busy=%b brdy=%b want 0/0/0",
                     a_rdy, a_busy, b_rdy);
        end
        @(negedge clk);
        reset = 1'b0;
        run(0, 1, 0, 2'b10, 0, 32'h50, 0, d, f, lat, bc);
        checks++;
        if (d !== 32'h0 || f !== 1'b0) begin
            failures++;
            $display("FAIL abort_lw_50 got %h/%b want 0/0", d, f);
        end
        run(0, 0, 1, 2'b10, 0, 32'h40, 32'h11111111, d, f, lat, bc);
        run(0, 0, 1, 2'b10, 0, 32'h60, 32'h22222222, d, f, lat, bc);
        @(negedge clk);
        memRead = 1; size = 2'b10; address = 32'h40;
        @(posedge clk);
        #1;
        memRead = 0; address = 32'h60;
        d = 'x;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (a_rdy) begin
                d = a_data;
                break;
            end
        end
        checks++;
        if (d !== 32'h11111111) begin
            failures++;
            $display("FAIL addr_hold got %h want 11111111", d);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d; logic f; int lat, bc;
        int          hit;
        logic [31:0] ex [3] = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        run(1, 0, 1, 2'b10, 0, 32'h10, ex[0], d, f, lat, bc);
        checks++;
        if (lat !== 1 || bc !== 1 || f !== 1'b0) begin
            failures++;
            $display("FAIL zero_wait got lat=%0d busy=%0d f=%b want 1/1/0",
                     lat, bc, f);
        end
        run(1, 0, 1, 2'b10, 0, 32'h14, ex[1], d, f, lat, bc);
        run(1, 0, 1, 2'b10, 0, 32'h18, ex[2], d, f, lat, bc);
        @(negedge clk);
        memRead = 1; size = 2'b10; address = 32'h10;
        hit = 0;
        for (int e = 0; e <= 12 && hit < 3; e++) begin
            @(posedge clk);
            #1;
            if (b_rdy) begin
                checks++;
                if (e !== 3 * hit + 1 || b_data !== ex[hit]) begin
                    failures++;
                    $display("FAIL b2b_%0d got edge=%0d d=%h want %0d/%h",
                             hit, e, b_data, 3 * hit + 1, ex[hit]);
                end
                hit++;
                address = 32'h10 + 32'(4 * hit);
                if (hit == 3) memRead = 0;
            end
        end
        checks++;
        if (hit !== 3) begin
            failures++;
            $display("FAIL b2b_count got %0d want 3", hit);
        end
        memRead = 0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_subword_load();
        test_subword_store();
        test_faults();
        test_abort_and_hold();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_wait_ctrl.md
Name: mem_wait_ctrl

Overview:
- Parametrised successor to the single-cycle byte-array memory in the multicycle datapath.
- Adds configurable depth, byte/half/word access with sign/zero extension, and programmable wait states.
- Adds a request/ready handshake and fault reporting, so the control FSM can stall on memory.
- Sits between the mem_mux address path and the IR/MDR registers.

Parameters:
- ADDR_WIDTH, 8, byte-address bits actually decoded; capacity is 2^ADDR_WIDTH bytes.
- WAIT_CYCLES, 2, extra cycles inserted between request acceptance and access completion (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- address  input  32  byte address
- writeData  input  32  store data, right-aligned
- memRead  input  1  read request
- memWrite  input  1  write request
- size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- unsignedLoad  input  1  1 = zero-extend sub-word loads, 0 = sign-extend
- memData  output  32  registered load result
- memReady  output  1  one-cycle completion pulse
- busy  output  1  high while a request is in flight
- accessFault  output  1  one-cycle pulse coincident with memReady when the access faulted

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset effects:
  - All 2^ADDR_WIDTH bytes are cleared to 0.
  - State goes to IDLE.
  - memData=0, memReady=0, busy=0, accessFault=0.
- Reset in any state aborts the access in flight: no write is performed and no memReady pulse is issued.
- FSM states:
  - IDLE: if memRead|memWrite is seen at an edge, latch address, writeData, size, unsignedLoad and op; load cnt=WAIT_CYCLES; go to WAIT.
  - WAIT: if cnt!=0, decrement and stay. If cnt==0, perform the access (write array, or capture memData) and go to RESP.
  - RESP: memReady=1 for this one cycle; accessFault=1 too if the access faulted. Unconditionally return to IDLE.
- busy=1 in WAIT and RESP, 0 in IDLE.
- Latency: memReady rises WAIT_CYCLES+1 cycles after the accepting edge.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Request lines are sampled only in IDLE. Changes while busy are ignored; the latched copies are used.
- The requester must deassert memRead/memWrite in the RESP cycle. A request still high in the following IDLE cycle is treated as a new access.
- Fault conditions, evaluated on the latched request:
  - size==11.
  - Misaligned address: half access with address[0]=1; word access with address[1:0]!=0.
  - Out of range: any address bit at index >= ADDR_WIDTH is set.
  - memRead and memWrite both high at acceptance.
- On fault: no array write; memData <= 0; accessFault pulses with memReady.
- Loads:
  - Little-endian.
  - Byte/half results are sign- or zero-extended to 32 bits per unsignedLoad.
  - Word loads ignore unsignedLoad.
- memData updates only at completion of a read or a faulting access. It holds its value across writes and idle cycles.
- Stores:
  - Byte writes writeData[7:0] at address.
  - Half writes [7:0] to address and [15:8] to address+1.
  - Word writes all four bytes, LSB at address.
- Aligned in-range accesses never straddle the top of the array. No wrap-around occurs; out-of-range addresses fault instead.

Test Plan:
1. Reset, then sw 0x8BADF00D @0x40 with WAIT_CYCLES=2.
   - busy high 3 cycles; memReady pulses exactly 3 cycles after the accepting edge; accessFault=0.
   - A following lw @0x40 returns memData=0x8BADF00D.
2. With the word above in memory:
   - lb @0x43 -> 0xFFFFFF8B; lbu -> 0x0000008B.
   - lh @0x42 -> 0xFFFF8BAD; lhu -> 0x00008BAD.
   - lb @0x40 -> 0x0000000D.
3. Sub-word stores:
   - sb 0x000000AA @0x41, then lw @0x40 -> 0x8BADAA0D.
   - sh 0xCAFE1234 @0x42, then lw @0x40 -> 0x1234AA0D.
4. Faults: lw @0x41, sh @0x43, lw @0x100, size=11, and memRead&memWrite together.
   - Each gives accessFault=1 with memReady, and memData=0.
   - lw @0x40 afterwards still returns 0x1234AA0D (no corruption).
5. Abort and request hold:
   - Accept sw 0xFFFFFFFF @0x50, then assert reset one cycle later -> no memReady, busy=0 after reset; lw @0x50 -> 0.
   - Change address to 0x60 while busy on lw @0x40 -> result is still from 0x40.
6. Zero-wait instance (WAIT_CYCLES=0):
   - memReady appears 1 cycle after acceptance.
   - Back-to-back requests held high complete every 3 cycles with correct data.
